// File: rtl/score_sequencer_if.sv
// Score ROM bus between the sequencer (master) and a synchronous-read ROM (slave).
// Read data is valid the cycle after rom_en is asserted.
interface score_sequencer_if #(
    parameter int ADDR_W = 8
) ();
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_data;

    modport master (output rom_en, output rom_addr, input rom_data);
    modport slave  (input rom_en, input rom_addr, output rom_data);
endinterface

// File: rtl/score_sequencer.sv
// Score sequencer: walks a score ROM one 32-bit step at a time and presents four
// note tracks, holding each step for its duration in tempo beats.
module score_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int TICK_DIV = 375000,
    parameter int DIV_W    = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_pause,
    input  logic              i_loop_en,
    score_sequencer_if.master rom,
    output logic [5:0]        o_track0,
    output logic [5:0]        o_track1,
    output logic [5:0]        o_track2,
    output logic [5:0]        o_track3,
    output logic              o_playing,
    output logic              o_done
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_LOAD, S_PLAY, S_DONE
    } state_t;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    state_t            r_state, w_state_next;
    logic [ADDR_W-1:0] r_ptr, w_ptr_next;
    logic [DIV_W-1:0]  r_div, w_div_next;
    logic [7:0]        r_beat, w_beat_next;
    logic [31:0]       r_step, w_step_next;
    logic [3:0][5:0]   r_track, w_track_next;
    logic [3:0][5:0]   w_step_tracks;
    logic              r_rom_en, w_rom_en_next;
    logic [ADDR_W-1:0] r_rom_addr, w_rom_addr_next;
    logic              r_playing, w_playing_next;
    logic              r_done, w_done_next;
    logic              w_beat;
    logic              w_end_marker;

    assign w_step_tracks = r_step[31:8];
    assign w_end_marker  = (r_step[7:0] == 8'd0);
    assign w_beat        = (r_state == S_PLAY) && !i_pause && (r_div == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (i_stop) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (i_start) w_state_next = S_FETCH;
                S_FETCH: w_state_next = S_WAIT;
                S_WAIT:  w_state_next = S_LOAD;
                // An end marker at address 0 must not loop, or an empty score spins forever
                S_LOAD: begin
                    if (!w_end_marker)                         w_state_next = S_PLAY;
                    else if (i_loop_en && r_ptr != '0)         w_state_next = S_FETCH;
                    else                                       w_state_next = S_DONE;
                end
                S_PLAY:  if (w_beat && r_beat == 8'd1) w_state_next = S_FETCH;
                S_DONE:  if (i_start) w_state_next = S_FETCH;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_ptr_next      = r_ptr;
        w_div_next      = r_div;
        w_beat_next     = r_beat;
        w_step_next     = r_step;
        w_track_next    = r_track;
        w_rom_addr_next = r_rom_addr;
        if (i_stop) begin
            w_ptr_next   = '0;
            w_track_next = '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        w_ptr_next = '0;
                        w_div_next = '0;
                    end
                end
                S_WAIT: w_step_next = rom.rom_data;
                S_LOAD: begin
                    if (!w_end_marker) begin
                        w_track_next = w_step_tracks;
                        w_beat_next  = r_step[7:0];
                        w_ptr_next   = r_ptr + ADDR_W'(1);
                        w_div_next   = '0;
                    end else if (i_loop_en && r_ptr != '0) begin
                        w_ptr_next = '0;
                    end else begin
                        w_track_next = '0;
                    end
                end
                S_PLAY: begin
                    if (w_beat) begin
                        w_div_next  = '0;
                        w_beat_next = r_beat - 8'd1;
                    end else if (!i_pause) begin
                        w_div_next = r_div + DIV_W'(1);
                    end
                end
                default: ;
            endcase
        end
        // Outputs are registered from the next state so they line up with it
        w_rom_en_next = (w_state_next == S_FETCH);
        if (w_rom_en_next) w_rom_addr_next = w_ptr_next;
        w_playing_next = (w_state_next == S_FETCH) || (w_state_next == S_WAIT) ||
                         (w_state_next == S_LOAD)  || (w_state_next == S_PLAY);
        w_done_next    = (w_state_next == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_div      <= '0;
            r_beat     <= '0;
            r_step     <= '0;
            r_track    <= '0;
            r_rom_en   <= 1'b0;
            r_rom_addr <= '0;
            r_playing  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_ptr      <= w_ptr_next;
            r_div      <= w_div_next;
            r_beat     <= w_beat_next;
            r_step     <= w_step_next;
            r_track    <= w_track_next;
            r_rom_en   <= w_rom_en_next;
            r_rom_addr <= w_rom_addr_next;
            r_playing  <= w_playing_next;
            r_done     <= w_done_next;
        end
    end

    assign rom.rom_en   = r_rom_en;
    assign rom.rom_addr = r_rom_addr;
    assign o_track0     = r_track[0];
    assign o_track1     = r_track[1];
    assign o_track2     = r_track[2];
    assign o_track3     = r_track[3];
    assign o_playing    = r_playing;
    assign o_done       = r_done;
endmodule

// File: tb/tb_score_sequencer.sv
// Bench for score_sequencer: a clock-count playback model checked every cycle,
// plus directed scenarios with hand-computed cycle positions.
module tb_score_sequencer;
    localparam int TICK = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, stop = 1'b0, pause = 1'b0, loop_en = 1'b0, start2 = 1'b0;
    logic [5:0] t0, t1, t2, t3, u0, u1, u2, u3;
    logic playing, done, playing2, done2;
    logic [31:0] rom_mem [256];
    logic [31:0] rom2_mem [4];
    int n_vec = 0;
    int n_mis = 0;

    score_sequencer_if #(.ADDR_W(8)) rif ();
    score_sequencer_if #(.ADDR_W(2)) rif2 ();

    score_sequencer #(.ADDR_W(8), .TICK_DIV(TICK), .DIV_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_stop(stop), .i_pause(pause),
        .i_loop_en(loop_en), .rom(rif), .o_track0(t0), .o_track1(t1), .o_track2(t2),
        .o_track3(t3), .o_playing(playing), .o_done(done));

    score_sequencer #(.ADDR_W(2), .TICK_DIV(TICK), .DIV_W(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .i_start(start2), .i_stop(1'b0), .i_pause(1'b0),
        .i_loop_en(1'b0), .rom(rif2), .o_track0(u0), .o_track1(u1), .o_track2(u2),
        .o_track3(u3), .o_playing(playing2), .o_done(done2));

    always #5 clk = ~clk;

    always @(posedge clk) if (rif.rom_en)  rif.rom_data  <= rom_mem[rif.rom_addr];
    always @(posedge clk) if (rif2.rom_en) rif2.rom_data <= rom2_mem[rif2.rom_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Playback model: phases plus a count of unpaused clocks left in the step
    localparam int M_IDLE = 0, M_FETCH = 1, M_WAIT = 2, M_LOAD = 3, M_PLAY = 4, M_DONE = 5;
    int m_phase, m_ptr, m_remain;
    logic [7:0] m_addr;
    logic [3:0][5:0] m_trk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= M_IDLE; m_ptr <= 0; m_remain <= 0; m_addr <= 8'd0; m_trk <= '0;
        end else if (stop) begin
            m_phase <= M_IDLE; m_ptr <= 0; m_trk <= '0;
        end else begin
            case (m_phase)
                M_IDLE, M_DONE: if (start) begin
                    m_phase <= M_FETCH; m_ptr <= 0; m_addr <= 8'd0;
                end
                M_FETCH: m_phase <= M_WAIT;
                M_WAIT:  m_phase <= M_LOAD;
                M_LOAD: begin
                    if (rom_mem[m_ptr][7:0] != 8'd0) begin
                        m_trk    <= rom_mem[m_ptr][31:8];
                        m_remain <= int'(rom_mem[m_ptr][7:0]) * TICK;
                        m_ptr    <= (m_ptr + 1) % 256;
                        m_phase  <= M_PLAY;
                    end else if (loop_en && m_ptr != 0) begin
                        m_ptr <= 0; m_addr <= 8'd0; m_phase <= M_FETCH;
                    end else begin
                        m_trk <= '0; m_phase <= M_DONE;
                    end
                end
                M_PLAY: if (!pause) begin
                    m_remain <= m_remain - 1;
                    if (m_remain == 1) begin
                        m_phase <= M_FETCH; m_addr <= m_ptr[7:0];
                    end
                end
                default: m_phase <= M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("cycle",
            {rif.rom_en, rif.rom_addr, t3, t2, t1, t0, playing, done},
            {m_phase == M_FETCH, m_addr, m_trk,
             (m_phase >= M_FETCH && m_phase <= M_PLAY), m_phase == M_DONE});
    end

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int first, bad, nf, done_at, hi2;
        int addrs [8];
        int exp3 [6];
        int exp7 [6];
        exp3 = '{0, 1, 2, 0, 1, 2};
        exp7 = '{0, 1, 2, 3, 0, 1};
        for (int i = 0; i < 256; i++) rom_mem[i] = 32'd0;
        for (int i = 0; i < 4; i++) rom2_mem[i] = {6'(i + 1), 6'd2, 6'd3, 6'd4, 8'd1};

        nclk(2);
        chk("reset", {rif.rom_en, rif.rom_addr, t3, t2, t1, t0, playing, done}, 64'd0);
        rst_n = 1'b1;
        nclk(2);

        // Single 3-beat step followed by an end marker
        rom_mem[0] = 32'h0C30_5A03; rom_mem[1] = 32'd0;
        pulse_start();
        chk("t1_fetch0", {rif.rom_en, rif.rom_addr, playing}, {1'b1, 8'd0, 1'b1});
        nclk(3);
        chk("t1_notes", {t3, t2, t1, t0}, {6'd3, 6'd3, 6'd1, 6'h1A});
        nclk(11);
        chk("t1_hold", {rif.rom_en, t0}, {1'b0, 6'h1A});
        nclk(1);
        chk("t1_fetch1", {rif.rom_en, rif.rom_addr, t0}, {1'b1, 8'd1, 6'h1A});
        nclk(2);
        chk("t1_notyet", {done, playing}, {1'b0, 1'b1});
        nclk(1);
        chk("t1_done", {done, playing, t3, t2, t1, t0}, {1'b1, 1'b0, 24'd0});
        $display("scenario single-step checked");

        // 2-beat step with a 10-clock pause after the first beat
        rom_mem[0] = {6'd5, 6'd6, 6'd7, 6'd8, 8'd2};
        pulse_start();
        first = 0; bad = 0;
        for (int k = 2; k <= 30; k++) begin
            @(negedge clk);
            if (k == 8)  pause = 1'b1;
            if (k == 18) pause = 1'b0;
            if (rif.rom_en && first == 0) first = k;
            if (k >= 4 && k <= 24 && {t3, t2, t1, t0} != {6'd5, 6'd6, 6'd7, 6'd8}) bad++;
            if (k == 25) chk("t2_done", {done, t0}, {1'b1, 6'd0});
        end
        chk("t2_refetch", first, 22);
        chk("t2_hold", bad, 0);
        $display("scenario pause checked, refetch at cycle %0d", first);

        // Looping two-step score, loop_en dropped before the second end marker
        rom_mem[0] = {6'd1, 6'd2, 6'd3, 6'd4, 8'd1};
        rom_mem[1] = {6'd9, 6'd10, 6'd11, 6'd12, 8'd1};
        rom_mem[2] = 32'd0;
        loop_en = 1'b1;
        pulse_start();
        nf = 0; done_at = 0;
        if (rif.rom_en) begin addrs[nf] = int'(rif.rom_addr); nf++; end
        for (int k = 2; k <= 40; k++) begin
            @(negedge clk);
            if (k == 25) loop_en = 1'b0;
            if (rif.rom_en && nf < 8) begin addrs[nf] = int'(rif.rom_addr); nf++; end
            if (done && done_at == 0) done_at = k;
        end
        chk("t3_nfetch", nf, 6);
        for (int i = 0; i < 6; i++) chk($sformatf("t3_addr%0d", i), addrs[i], exp3[i]);
        chk("t3_done_at", done_at, 35);
        $display("scenario loop checked, %0d fetches, done at %0d", nf, done_at);

        // Empty score with loop_en: straight to DONE, no refetch
        rom_mem[0] = 32'd0;
        loop_en = 1'b1;
        pulse_start();
        nf = 0; done_at = 0;
        for (int k = 2; k <= 12; k++) begin
            @(negedge clk);
            if (rif.rom_en) nf++;
            if (done && done_at == 0) done_at = k;
        end
        loop_en = 1'b0;
        chk("t4_done_at", done_at, 4);
        chk("t4_refetch", nf, 0);
        $display("scenario empty checked");

        // Stop during PLAY, then start+stop together from IDLE
        rom_mem[0] = {6'd7, 6'd7, 6'd7, 6'd9, 8'd3}; rom_mem[1] = 32'd0;
        pulse_start();
        nclk(5);
        chk("t5_playing", {playing, t0}, {1'b1, 6'd9});
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("t5_stop", {playing, rif.rom_en, t3, t2, t1, t0, done}, 64'd0);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("t5_both", {playing, rif.rom_en}, 2'b00);
        nclk(4);
        chk("t5_idle", {playing, done, rif.rom_en}, 3'b000);
        $display("scenario stop checked");

        // Asynchronous reset in the WAIT cycle of the second step
        rom_mem[0] = {6'd1, 6'd2, 6'd3, 6'd4, 8'd1};
        rom_mem[1] = {6'd9, 6'd10, 6'd11, 6'd12, 8'd1};
        rom_mem[2] = 32'd0;
        pulse_start();
        nclk(7);
        chk("t6_fetch1", {rif.rom_en, rif.rom_addr}, {1'b1, 8'd1});
        @(posedge clk);
        #2;
        chk("t6_pre", {playing, rif.rom_addr, t0}, {1'b1, 8'd1, 6'd4});
        rst_n = 1'b0;
        #1;
        chk("t6_async", {rif.rom_en, rif.rom_addr, t3, t2, t1, t0, playing, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("scenario async reset checked");

        // 2-bit address sequencer with no end marker wraps 3 -> 0
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        nf = 0; hi2 = 0;
        if (rif2.rom_en) begin addrs[nf] = int'(rif2.rom_addr); nf++; end
        for (int k = 2; k <= 40; k++) begin
            @(negedge clk);
            if (rif2.rom_en && nf < 8) begin addrs[nf] = int'(rif2.rom_addr); nf++; end
            if (done2 || !playing2) hi2++;
            if (k == 4) chk("t7_notes", {u3, u2, u1, u0}, {6'd1, 6'd2, 6'd3, 6'd4});
        end
        chk("t7_nfetch", nf, 6);
        for (int i = 0; i < 6; i++) chk($sformatf("t7_addr%0d", i), addrs[i], exp7[i]);
        chk("t7_never_done", hi2, 0);
        $display("scenario wrap checked");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
